// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the core and the loader.
// Define ARB_CPU_PRIORITY_EN to replace round-robin with fixed cpu-first priority.
module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk_50MHz,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic              owner
);

   // state  | meaning
   // IDLE   | no transaction; arbitrate on sampled requests
   // ACCESS | memory samples the registered port
   // WAIT   | read latency, RD_LAT cycles; q captured on the last one
   // DONE   | one-cycle ack to the owner
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_wren_q, mem_wren_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              owner_q, owner_d;
   logic              last_ldr_q, last_ldr_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              ldr_ack_q, ldr_ack_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
   logic              grant_ldr;
   logic              grant_any;

   always_comb begin
      grant_any = cpu_req | ldr_req;
`ifdef ARB_CPU_PRIORITY_EN
      grant_ldr = ldr_req & ~cpu_req;
`else
      grant_ldr = ldr_req & (~cpu_req | ~last_ldr_q);
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      mem_wren_d  = 1'b0;
      mem_data_d  = mem_data_q;
      owner_d     = owner_q;
      last_ldr_d  = last_ldr_q;
      cpu_ack_d   = 1'b0;
      ldr_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               state_d    = ST_ACCESS;
               owner_d    = grant_ldr;
               last_ldr_d = grant_ldr;
               mem_addr_d = grant_ldr ? ldr_addr  : cpu_addr;
               mem_wren_d = grant_ldr ? ldr_we    : cpu_we;
               mem_data_d = grant_ldr ? ldr_wdata : cpu_wdata;
            end
         end
         ST_ACCESS: begin
            if (mem_wren_q) begin
               state_d   = ST_DONE;
               cpu_ack_d = ~owner_q;
               ldr_ack_d = owner_q;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(RD_LAT - 1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d   = ST_DONE;
               cpu_ack_d = ~owner_q;
               ldr_ack_d = owner_q;
               if (owner_q) ldr_rdata_d = mem_q;
               else         cpu_rdata_d = mem_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wren_q  <= 1'b0;
         mem_data_q  <= '0;
         owner_q     <= 1'b0;
         last_ldr_q  <= 1'b1;   // cpu wins the first tie
         cpu_ack_q   <= 1'b0;
         ldr_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wren_q  <= mem_wren_d;
         mem_data_q  <= mem_data_d;
         owner_q     <= owner_d;
         last_ldr_q  <= last_ldr_d;
         cpu_ack_q   <= cpu_ack_d;
         ldr_ack_q   <= ldr_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wren  = mem_wren_q;
   assign mem_data  = mem_data_q;
   assign owner     = owner_q;
   assign busy      = (state_q != ST_IDLE);
   assign cpu_ack   = cpu_ack_q;
   assign ldr_ack   = ldr_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing model.
// Build with ARB_CPU_PRIORITY_EN to check the fixed-priority variant.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 3;

   logic              clk_50MHz = 1'b0;
   logic              reset_n;
   logic              cpu_req, cpu_we, ldr_req, ldr_we;
   logic [ADDR_W-1:0] cpu_addr, ldr_addr, mem_addr;
   logic [DATA_W-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, mem_data, mem_q;
   logic              cpu_ack, ldr_ack, mem_wren, busy, owner;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk_50MHz(clk_50MHz), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q),
      .busy(busy), .owner(owner)
   );

   initial forever #10 clk_50MHz = ~clk_50MHz;

   function automatic logic [DATA_W-1:0] init_val(input int i);
      return DATA_W'(i * 257) ^ 16'h5A5A;
   endfunction

   // memory instance with RD_LAT-deep read pipeline
   logic              mem_fill;
   logic [DATA_W-1:0] mem_arr [256];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   always @(posedge clk_50MHz) begin
      if (mem_fill) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
      end else if (mem_wren) begin
         mem_arr[mem_addr] <= mem_data;
      end
      rd_pipe[0] <= mem_arr[mem_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_q = rd_pipe[RD_LAT-1];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // reference model: one transaction at a time, timing from plain arithmetic
   logic [DATA_W-1:0] ref_mem [256];
   bit                m_active, m_own, m_last, m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   int                m_grant, m_ack, m_next_ok;
   logic [DATA_W-1:0] exp_rdata [2];

   // requester drivers (index 0 = cpu, 1 = loader)
   bit                d_req [2];
   logic              d_we [2];
   logic [ADDR_W-1:0] d_addr [2];
   logic [DATA_W-1:0] d_wdata [2];
   int                d_gap [2];
   int                sc_cpu = 0, sc_ldr = 0;
   bit                allow_new;

   task automatic model_reset();
      m_active  = 0;
      m_own     = 0;
      m_last    = 1;
      m_we      = 0;
      m_addr    = '0;
      m_wdata   = '0;
      m_next_ok = 0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
   endtask

   task automatic new_txn(input int r);
      if (r == 0 && sc_cpu == 0) begin
         d_we[0] = 1'b1; d_addr[0] = 8'h10; d_wdata[0] = 16'hA5A5; sc_cpu++;
      end else if (r == 0 && sc_cpu == 1) begin
         d_we[0] = 1'b0; d_addr[0] = 8'h10; d_wdata[0] = 16'h0000; sc_cpu++;
      end else if (r == 1 && sc_ldr == 0) begin
         d_we[1] = 1'b0; d_addr[1] = 8'hFF; d_wdata[1] = 16'h0000; sc_ldr++;
      end else begin
         d_we[r]    = 1'($urandom_range(0, 1));
         d_addr[r]  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                   : 8'($urandom_range(240, 255));
         d_wdata[r] = 16'($urandom);
      end
   endtask

   task automatic apply_pins();
      cpu_req = d_req[0]; cpu_we = d_we[0]; cpu_addr = d_addr[0]; cpu_wdata = d_wdata[0];
      ldr_req = d_req[1]; ldr_we = d_we[1]; ldr_addr = d_addr[1]; ldr_wdata = d_wdata[1];
   endtask

   task automatic tick();
      int w;
      bit done;
      @(posedge clk_50MHz);
      #1;
      cyc++;
      if (m_active && cyc > m_ack) m_active = 0;
      if (m_active && cyc == m_ack) begin
         if (m_we) ref_mem[m_addr] = m_wdata;
         else      exp_rdata[m_own] = ref_mem[m_addr];
      end
      if (!m_active && cyc >= m_next_ok && (d_req[0] || d_req[1])) begin
`ifdef ARB_CPU_PRIORITY_EN
         w = d_req[0] ? 0 : 1;
`else
         if (d_req[0] && d_req[1]) w = m_last ? 0 : 1;
         else                      w = d_req[1] ? 1 : 0;
`endif
         m_own     = 1'(w);
         m_last    = 1'(w);
         m_we      = d_we[w];
         m_addr    = d_addr[w];
         m_wdata   = d_wdata[w];
         m_grant   = cyc;
         m_ack     = cyc + (m_we ? 1 : 1 + RD_LAT);
         m_next_ok = m_ack + 2;
         m_active  = 1;
      end
      check("busy",      32'(busy),      32'(m_active));
      check("mem_wren",  32'(mem_wren),  32'(m_active && cyc == m_grant && m_we));
      check("mem_addr",  32'(mem_addr),  32'(m_addr));
      check("mem_data",  32'(mem_data),  32'(m_wdata));
      check("owner",     32'(owner),     32'(m_own));
      check("cpu_ack",   32'(cpu_ack),   32'(m_active && cyc == m_ack && !m_own));
      check("ldr_ack",   32'(ldr_ack),   32'(m_active && cyc == m_ack && m_own));
      check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata[0]));
      check("ldr_rdata", 32'(ldr_rdata), 32'(exp_rdata[1]));
      for (int r = 0; r < 2; r++) begin
         done = m_active && cyc == m_ack && (int'(m_own) == r);
         if (done) begin
            if (allow_new && $urandom_range(0, 1) == 1) begin
               new_txn(r);
            end else begin
               d_req[r] = 0;
               d_gap[r] = $urandom_range(0, 4);
            end
         end else if (d_req[r]) begin
            // after grant the port inputs are don't-care; scramble them
            if (m_active && int'(m_own) == r) begin
               d_we[r]    = 1'($urandom_range(0, 1));
               d_addr[r]  = 8'($urandom);
               d_wdata[r] = 16'($urandom);
            end
         end else if (allow_new) begin
            if (d_gap[r] == 0) begin
               d_req[r] = 1;
               new_txn(r);
            end else begin
               d_gap[r]--;
            end
         end
      end
      apply_pins();
   endtask

   initial begin
      reset_n  = 1'b0;
      mem_fill = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      model_reset();
      allow_new = 1;
      d_req[0] = 1; d_gap[0] = 0; new_txn(0);
      d_req[1] = 0; d_gap[1] = 12;
      d_we[1] = 1'b0; d_addr[1] = '0; d_wdata[1] = '0;
      apply_pins();
      repeat (3) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      mem_fill = 1'b0;
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_mem_wren",  32'(mem_wren),  32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_data",  32'(mem_data),  32'd0);
      check("rst_owner",     32'(owner),     32'd0);
      check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
      check("rst_ldr_ack",   32'(ldr_ack),   32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_ldr_rdata", 32'(ldr_rdata), 32'd0);
      reset_n = 1'b1;

      repeat (1500) tick();

      allow_new = 0;
      for (int k = 0; k < 200 && (m_active || d_req[0] || d_req[1]); k++) tick();
      repeat (3) tick();

      // reset during the ACCESS cycle of a cpu write must abort it
      d_req[0] = 1; d_we[0] = 1'b1; d_addr[0] = 8'h33; d_wdata[0] = 16'h1234;
      apply_pins();
      for (int k = 0; k < 20 && !(m_active && cyc == m_grant); k++) tick();
      check("abort_in_access", 32'(mem_wren), 32'd1);
      d_req[0] = 0;
      apply_pins();
      reset_n = 1'b0;
      #2;
      check("abort_mem_wren", 32'(mem_wren), 32'd0);
      check("abort_busy",     32'(busy),     32'd0);
      check("abort_owner",    32'(owner),    32'd0);
      repeat (2) @(posedge clk_50MHz);
      #1;
      check("abort_cpu_ack",  32'(cpu_ack),  32'd0);
      check("abort_busy2",    32'(busy),     32'd0);
      model_reset();
      @(negedge clk_50MHz);
      reset_n = 1'b1;

      d_req[0] = 1; d_we[0] = 1'b0; d_addr[0] = 8'h33; d_wdata[0] = 16'h0000;
      apply_pins();
      for (int k = 0; k < RD_LAT + 6; k++) tick();
      check("abort_no_write", 32'(cpu_rdata), 32'(init_val(8'h33)));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
